pattern_checker: RTL and testbench
==================================

// Module: pattern_checker
// PURPOSE
//  Sink stage directly downstream of the 800x600 test-pattern source. Drives
//  VideoReady and consumes the 24-bit pixel stream. Regenerates the expected
//  4-quadrant, 1 Hz polarity-toggling pattern and compares every accepted
//  pixel. Reports sticky and saturating error status for board-level
//  self-test.
// PARAMETERS
//  VISIBLE_WIDTH   10'd800    pixels per line
//  VISIBLE_HEIGHT  10'd600    lines per frame
//  FRAME_RATE      7'd72      frames per polarity period (one second)
//  Q1_COLOR        24'h00CC00 top-left quadrant colour (true polarity)
//  Q2_COLOR        24'h00CCCC top-right
//  Q3_COLOR        24'hFF9A26 bottom-left
//  Q4_COLOR        24'h9D26FF bottom-right
//  ERR_W           16         error counter width
// PORTS
//  clock         in   1   system clock
//  reset         in   1   synchronous, active-high
//  enable        in   1   1 = request pixels
//  clear_errors  in   1   1-cycle pulse: zero error_count and error_flag
//  VideoReady    out  1   request to source
//  VideoValid    in   1   1 = Video carries a pixel; accepted that cycle
//  Video         in   24  pixel {R,G,B}
//  error_count   out  ERR_W  mismatching pixels, saturating
//  error_flag    out  1   sticky: any mismatch since reset/clear
//  frame_done    out  1   1-cycle pulse: last pixel of a frame accepted
//  second_done   out  1   1-cycle pulse: last pixel of last frame accepted
// BEHAVIOUR
//  - Reset: all outputs 0. h=v=frame=0; polarity=0.
//  - VideoReady is registered: VideoReady <= enable & ~reset.
//  - Every cycle with VideoValid=1 is an accepted pixel, regardless of the
//    current VideoReady. The source delivers VideoValid one cycle after
//    Ready, so deasserting enable still accepts one trailing pixel.
//  - Position counters advance only on accepted pixels:
//    h 0..W-1, wrapping to 0; v increments at h=W-1 and wraps at H-1;
//    frame increments at the last pixel of a frame and wraps at
//    FRAME_RATE-1; polarity toggles on that wrap.
//  - Expected colour is selected by {v[5],h[6]}:
//    00=Q1, 01=Q2, 10=Q3, 11=Q4.
//    expected = polarity ? Qn : ~Qn. The first second after reset is
//    therefore inverted: pixel (0,0) is expected as 24'hFF33FF.
//  - Compare is combinational against the accepted pixel. error_count and
//    error_flag update on the same clock edge, so they are visible the
//    cycle after acceptance (1-cycle latency).
//  - error_count saturates at 2^ERR_W-1 and never wraps.
//  - clear_errors coincident with a mismatch: clear is applied first, then
//    the mismatch is counted. Result: error_count=1, error_flag=1.
//  - clear_errors does not touch position or polarity state.
//  - frame_done and second_done are registered. They pulse the cycle after
//    the last pixel is accepted; both pulse together on the second wrap.
//  - reset mid-frame: all counters, polarity and status return to their
//    reset values on the next edge. The source must be reset in the same
//    cycle to stay aligned.
// CONFIGURATION
//  PATTERN_CHECK_CAPTURE_EN defined:
//   - Adds outputs first_err_h[9:0], first_err_v[9:0], first_err_pix[23:0].
//   - These latch the position and data of the first mismatch after
//     reset/clear and hold until the next reset or clear_errors.
//   - Reset value of all three is 0.
//   - On a clear coincident with a mismatch, they capture that mismatch.
//  PATTERN_CHECK_CAPTURE_EN undefined: these ports and registers are absent.
// TESTING
//  1. Ideal source, enable=1 for 73 frames -> error_count=0, error_flag=0;
//     frame_done pulses 73 times; second_done pulses once after pixel
//     (799,599) of frame 71.
//  2. Q1 pixel driven as 24'hFF33FE at (0,0), frame 0 -> error_count=1 and
//     error_flag=1 one cycle later; with CAPTURE_EN, first_err=(0,0,FF33FE).
//  3. Check pixel (64,32) in frame 0 -> expected ~Q4 = 24'h62D900;
//     in frame 72 -> expected 24'h9D26FF.
//  4. ERR_W=4, all pixels wrong -> error_count holds 15; clear_errors
//     with a mismatch in the same cycle -> error_count=1.
//  5. Toggle enable 1/0 every 7 cycles -> VideoReady lags enable by 1
//     cycle; no false errors; positions track the accepted pixels only.
//  6. reset asserted at pixel (400,300) -> next cycle all outputs 0; after
//     release, a fresh frame from (0,0) checks clean.

Source files
------------

// File: rtl/pattern_checker.sv
// pattern_checker
//   Sink stage for the 800x600 test-pattern source. Requests pixels through
//   VideoReady, regenerates the expected 4-quadrant pattern (colour polarity
//   toggles once per FRAME_RATE frames) and compares every accepted pixel.
//   Error status is sticky (error_flag) and saturating (error_count).
//
// Ports
//   clock, reset        system clock; synchronous active-high reset
//   enable              1 = request pixels (VideoReady follows one cycle later)
//   clear_errors        1-cycle pulse: zero error_count / error_flag
//   VideoReady          registered request to the source
//   VideoValid, Video   pixel strobe and {R,G,B} data; every valid is accepted
//   error_count         mismatching pixels, saturates at 2^ERR_W-1
//   error_flag          sticky mismatch indicator
//   frame_done          pulse after the last pixel of a frame is accepted
//   second_done         pulse after the last pixel of the last frame of a period
//
// Optional feature (macro PATTERN_CHECK_CAPTURE_EN):
//   first_err_h/v/pix   position and data of the first mismatch since
//                       reset/clear_errors; zeroed by reset and clear_errors.

module pattern_checker #(
    parameter logic [9:0]  VISIBLE_WIDTH  = 10'd800,
    parameter logic [9:0]  VISIBLE_HEIGHT = 10'd600,
    parameter logic [6:0]  FRAME_RATE     = 7'd72,
    parameter logic [23:0] Q1_COLOR       = 24'h00CC00,
    parameter logic [23:0] Q2_COLOR       = 24'h00CCCC,
    parameter logic [23:0] Q3_COLOR       = 24'hFF9A26,
    parameter logic [23:0] Q4_COLOR       = 24'h9D26FF,
    parameter int unsigned ERR_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear_errors,
    output logic             VideoReady,
    input  logic             VideoValid,
    input  logic [23:0]      Video,
    output logic [ERR_W-1:0] error_count,
    output logic             error_flag,
    output logic             frame_done,
    output logic             second_done
`ifdef PATTERN_CHECK_CAPTURE_EN
    ,
    output logic [9:0]       first_err_h,
    output logic [9:0]       first_err_v,
    output logic [23:0]      first_err_pix
`endif
);

    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic [6:0]       frame_q, frame_d;
    logic             pol_q, pol_d;
    logic             ready_q, ready_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             fdone_q, fdone_d;
    logic             sdone_q, sdone_d;

    logic [23:0]      quad_color;
    logic [23:0]      expected;
    logic             mismatch;
    logic [ERR_W-1:0] cnt_base;
    logic             flag_base;

`ifdef PATTERN_CHECK_CAPTURE_EN
    logic [9:0]  cap_h_q, cap_h_d;
    logic [9:0]  cap_v_q, cap_v_d;
    logic [23:0] cap_pix_q, cap_pix_d;
`endif

    always_comb begin
        case ({v_q[5], h_q[6]})
            2'b00:   quad_color = Q1_COLOR;
            2'b01:   quad_color = Q2_COLOR;
            2'b10:   quad_color = Q3_COLOR;
            default: quad_color = Q4_COLOR;
        endcase
        // Polarity 0 (the first period after reset) shows the inverted pattern.
        expected = pol_q ? quad_color : ~quad_color;
        mismatch = VideoValid && (Video != expected);

        // Clear takes effect before a coincident mismatch is counted.
        cnt_base  = clear_errors ? '0 : cnt_q;
        flag_base = clear_errors ? 1'b0 : flag_q;

        ready_d = enable;
        cnt_d   = cnt_base;
        flag_d  = flag_base | mismatch;
        if (mismatch && (cnt_base != '1)) begin
            cnt_d = cnt_base + ERR_W'(1);
        end

        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        pol_d   = pol_q;
        fdone_d = 1'b0;
        sdone_d = 1'b0;
        if (VideoValid) begin
            if (h_q == VISIBLE_WIDTH - 10'd1) begin
                h_d = '0;
                if (v_q == VISIBLE_HEIGHT - 10'd1) begin
                    v_d     = '0;
                    fdone_d = 1'b1;
                    if (frame_q == FRAME_RATE - 7'd1) begin
                        frame_d = '0;
                        pol_d   = ~pol_q;
                        sdone_d = 1'b1;
                    end else begin
                        frame_d = frame_q + 7'd1;
                    end
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end

`ifdef PATTERN_CHECK_CAPTURE_EN
        cap_h_d   = cap_h_q;
        cap_v_d   = cap_v_q;
        cap_pix_d = cap_pix_q;
        if (clear_errors) begin
            cap_h_d   = '0;
            cap_v_d   = '0;
            cap_pix_d = '0;
        end
        // flag_base low means no mismatch has been seen since reset/clear.
        if (mismatch && !flag_base) begin
            cap_h_d   = h_q;
            cap_v_d   = v_q;
            cap_pix_d = Video;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
            pol_q   <= 1'b0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            fdone_q <= 1'b0;
            sdone_q <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
            pol_q   <= pol_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            fdone_q <= fdone_d;
            sdone_q <= sdone_d;
        end
    end

`ifdef PATTERN_CHECK_CAPTURE_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            cap_h_q   <= '0;
            cap_v_q   <= '0;
            cap_pix_q <= '0;
        end else begin
            cap_h_q   <= cap_h_d;
            cap_v_q   <= cap_v_d;
            cap_pix_q <= cap_pix_d;
        end
    end

    assign first_err_h   = cap_h_q;
    assign first_err_v   = cap_v_q;
    assign first_err_pix = cap_pix_q;
`endif

    assign VideoReady  = ready_q;
    assign error_count = cnt_q;
    assign error_flag  = flag_q;
    assign frame_done  = fdone_q;
    assign second_done = sdone_q;

endmodule

// File: tb/tb_pattern_checker.sv
// tb_pattern_checker
//   Scoreboard bench for pattern_checker using a reduced 130x40 raster with
//   3 frames per polarity period (keeps every quadrant select bit exercised)
//   and a 4-bit error counter so saturation is reachable.

module tb_pattern_checker;

    localparam int W  = 130;
    localparam int H  = 40;
    localparam int FR = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear_errors = 1'b0;
    logic        VideoReady;
    logic        VideoValid = 1'b0;
    logic [23:0] Video = '0;
    logic [3:0]  error_count;
    logic        error_flag;
    logic        frame_done;
    logic        second_done;
`ifdef PATTERN_CHECK_CAPTURE_EN
    logic [9:0]  first_err_h;
    logic [9:0]  first_err_v;
    logic [23:0] first_err_pix;
`endif

    pattern_checker #(
        .VISIBLE_WIDTH (10'd130),
        .VISIBLE_HEIGHT(10'd40),
        .FRAME_RATE    (7'd3),
        .ERR_W         (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .clear_errors (clear_errors),
        .VideoReady   (VideoReady),
        .VideoValid   (VideoValid),
        .Video        (Video),
        .error_count  (error_count),
        .error_flag   (error_flag),
        .frame_done   (frame_done),
        .second_done  (second_done)
`ifdef PATTERN_CHECK_CAPTURE_EN
        ,
        .first_err_h  (first_err_h),
        .first_err_v  (first_err_v),
        .first_err_pix(first_err_pix)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rdy;
        logic [3:0]  cnt;
        logic        flag;
        logic        fd;
        logic        sd;
        logic [9:0]  ch;
        logic [9:0]  cv;
        logic [23:0] cp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference state
    int          m_h = 0, m_v = 0, m_frame = 0, m_cnt = 0;
    bit          m_pol = 0, m_flag = 0;
    logic [9:0]  m_ch = '0, m_cv = '0;
    logic [23:0] m_cp = '0;
    bit          prev_en = 0;

    function automatic logic [23:0] model_color(input int h, input int v, input bit pol);
        logic [9:0]  hh;
        logic [9:0]  vv;
        logic [23:0] q;
        hh = 10'(h);
        vv = 10'(v);
        case ({vv[5], hh[6]})
            2'b00:   q = 24'h00CC00;
            2'b01:   q = 24'h00CCCC;
            2'b10:   q = 24'hFF9A26;
            default: q = 24'h9D26FF;
        endcase
        return pol ? q : ~q;
    endfunction

    // Drive one cycle of inputs, advance the reference, queue its expected outputs.
    task automatic step(input bit en, input bit val, input logic [23:0] pix,
                        input bit clr, input bit rst);
        exp_t e;
        bit   fbase;
        enable = en; VideoValid = val; Video = pix; clear_errors = clr; reset = rst;
        e.fd = 0; e.sd = 0;
        if (rst) begin
            m_h = 0; m_v = 0; m_frame = 0; m_pol = 0; m_cnt = 0; m_flag = 0;
            m_ch = '0; m_cv = '0; m_cp = '0;
            e.rdy = 0;
        end else begin
            e.rdy = en;
            fbase = clr ? 1'b0 : m_flag;
            if (clr) begin
                m_cnt = 0; m_ch = '0; m_cv = '0; m_cp = '0;
            end
            if (val) begin
                if (pix !== model_color(m_h, m_v, m_pol)) begin
                    if (!fbase) begin
                        m_ch = 10'(m_h); m_cv = 10'(m_v); m_cp = pix;
                    end
                    fbase = 1;
                    if (m_cnt < 15) m_cnt++;
                end
                if (m_h == W - 1) begin
                    m_h = 0;
                    if (m_v == H - 1) begin
                        m_v = 0;
                        e.fd = 1;
                        if (m_frame == FR - 1) begin
                            m_frame = 0; m_pol = ~m_pol; e.sd = 1;
                        end else begin
                            m_frame++;
                        end
                    end else begin
                        m_v++;
                    end
                end else begin
                    m_h++;
                end
            end
            m_flag = fbase;
        end
        e.cnt = 4'(m_cnt); e.flag = m_flag; e.ch = m_ch; e.cv = m_cv; e.cp = m_cp;
        @(posedge clock);
        exp_q.push_back(e);
        #1;
    endtask

    // Ideal source pixel; (64,32) uses the hand-derived values for that spot.
    function automatic logic [23:0] ideal_pix();
        if (m_h == 64 && m_v == 32) return m_pol ? 24'h9D26FF : 24'h62D900;
        return model_color(m_h, m_v, m_pol);
    endfunction

    task automatic stream_ideal(input int n);
        for (int i = 0; i < n; i++) begin
            step(1, 1, ideal_pix(), 0, 0);
        end
        prev_en = 1;
    endtask

    // Enable toggles every 7 cycles; the source answers one cycle after Ready.
    task automatic stream_toggle(input int n);
        bit en;
        for (int i = 0; i < n; i++) begin
            en = ((i / 7) % 2) == 0;
            step(en, prev_en, prev_en ? ideal_pix() : 24'h0, 0, 0);
            prev_en = en;
        end
    endtask

    // Monitor: every cycle the DUT presents its status, compare with the queue head.
    always @(negedge clock) begin
        exp_t e;
        bit   bad;
        cycle++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            bad = (VideoReady !== e.rdy) || (error_count !== e.cnt) ||
                  (error_flag !== e.flag) || (frame_done !== e.fd) ||
                  (second_done !== e.sd);
`ifdef PATTERN_CHECK_CAPTURE_EN
            bad = bad || (first_err_h !== e.ch) || (first_err_v !== e.cv) ||
                  (first_err_pix !== e.cp);
`endif
            if (bad) begin
                errors++;
                $display("FAIL status cyc=%0d got rdy=%b cnt=%0d flag=%b fd=%b sd=%b want rdy=%b cnt=%0d flag=%b fd=%b sd=%b cap=(%0d,%0d,%h)",
                         cycle, VideoReady, error_count, error_flag, frame_done, second_done,
                         e.rdy, e.cnt, e.flag, e.fd, e.sd, e.ch, e.cv, e.cp);
            end
        end
    end

    initial begin
        int guard;
        // Reset state
        repeat (3) step(0, 0, 24'h0, 0, 1);
        step(1, 0, 24'h0, 0, 0);
        // Wrong pixel at (0,0) frame 0: true-polarity Q1 inverted is FF33FF
        step(1, 1, 24'hFF33FE, 0, 0);
        step(1, 0, 24'h0, 1, 0);
        // Clean frames, including (64,32) of frame 0 expected as 62D900
        stream_ideal(W * H);
        stream_toggle(2000);
        // Run past the period wrap into the true-polarity period's (64,32)
        guard = 0;
        while (!(m_pol == 1 && m_v == 33) && guard < 30000) begin
            step(1, 1, ideal_pix(), 0, 0);
            guard++;
        end
        checks++;
        if (guard >= 30000) begin
            errors++;
            $display("FAIL wrap_bound got guard=%0d required < 30000", guard);
        end
        // Saturation, then clear coincident with a mismatch
        for (int i = 0; i < 20; i++) step(1, 1, ~ideal_pix(), 0, 0);
        step(1, 1, ~ideal_pix(), 1, 0);
        step(1, 1, ideal_pix(), 1, 0);
        // Reset mid-frame, then a fresh frame from (0,0)
        guard = 0;
        while (!(m_h == 65 && m_v == 20) && guard < 10000) begin
            step(1, 1, ideal_pix(), 0, 0);
            guard++;
        end
        step(1, 1, 24'h123456, 0, 1);
        step(1, 0, 24'h0, 0, 0);
        step(1, 1, 24'hFF33FF, 0, 0);
        stream_ideal(300);
        repeat (3) step(0, 0, 24'h0, 0, 0);
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
